// File: rtl/wb_stage_rv.sv
// Registered RV32 writeback stage: 2-entry skid buffer, load extraction, stallable RF write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage_rv #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] result_i,
    input  logic [XLEN-1:0] loaddata_i,
    input  logic            rf_ready_i,
    output logic            rdvalid_o,
    output logic [4:0]      rdnum_o,
    output logic [XLEN-1:0] rddata_o,
    output logic            retire_o,
    output logic [XLEN-1:0] retire_pc_o
`ifdef WB_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret_o
`endif
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic            req;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } slot_t;

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be nonzero");
    end

    slot_t out_q, out_n, skid_q, skid_n, in_slot;
    logic  out_valid, out_valid_n, skid_valid, skid_valid_n;
    logic  ready_q, ready_n;
    logic  accept, commit;

    logic unused_inst;
    assign unused_inst = ^inst_i[31:15];

    // Sub-word extraction; LH/LHU select the half by offset[1] only.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [XLEN-1:0] word);
        logic [XLEN-1:0] sb, sh;
        logic [7:0]      b;
        logic [15:0]     h;
        sb = word >> {off, 3'b000};
        sh = word >> {off[1], 4'b0000};
        b  = sb[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        logic writes_rd;
        case (inst_i[6:0])
            OP_OP, OP_OPIMM, OP_JALR, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
        in_slot.req  = writes_rd & (|inst_i[11:7]);
        in_slot.rd   = inst_i[11:7];
        in_slot.pc   = pc_i;
        in_slot.data = (inst_i[6:0] == OP_LOAD)
                     ? load_extract(inst_i[14:12], result_i[1:0], loaddata_i)
                     : result_i;
    end

    assign accept = valid_i & ready_q;
    assign commit = out_valid & ~rst & (rf_ready_i | ~out_q.req);

    // Slot movement; SKID is never written while full because ready tracks it.
    always_comb begin
        out_valid_n  = out_valid;
        skid_valid_n = skid_valid;
        out_n        = out_q;
        skid_n       = skid_q;
        if (commit) begin
            if (skid_valid) begin
                out_n        = skid_q;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                out_n = in_slot;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid) begin
                out_valid_n = 1'b1;
                out_n       = in_slot;
            end else begin
                skid_valid_n = 1'b1;
                skid_n       = in_slot;
            end
        end
        ready_n = ~skid_valid_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            out_q      <= out_n;
            skid_q     <= skid_n;
            ready_q    <= ready_n;
        end
    end

    assign ready_o     = ready_q;
    assign rdvalid_o   = out_valid & out_q.req & ~rst;
    assign rdnum_o     = out_q.rd;
    assign rddata_o    = out_q.data;
    assign retire_o    = commit;
    assign retire_pc_o = out_q.pc;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage_rv.sv
// Scoreboard bench for wb_stage_rv: driver pushes expected retirements, negedge monitor checks them.
module tb_wb_stage_rv;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [XLEN-1:0] pc_i = '0;
    logic [31:0]     inst_i = '0;
    logic [XLEN-1:0] result_i = '0;
    logic [XLEN-1:0] loaddata_i = '0;
    logic            rf_ready_i = 1'b0;
    logic            rdvalid_o;
    logic [4:0]      rdnum_o;
    logic [XLEN-1:0] rddata_o;
    logic            retire_o;
    logic [XLEN-1:0] retire_pc_o;
`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_o;
`endif

    wb_stage_rv #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .result_i(result_i), .loaddata_i(loaddata_i),
        .rf_ready_i(rf_ready_i), .rdvalid_o(rdvalid_o), .rdnum_o(rdnum_o),
        .rddata_o(rddata_o), .retire_o(retire_o), .retire_pc_o(retire_pc_o)
`ifdef WB_INSTRET_EN
        , .instret_o(instret_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t            sbq[$];
    int              tests = 0;
    int              fails = 0;
    longint unsigned n_ret = 0;
    bit              rst_q = 1'b1;
    bit              pend = 1'b0;
    exp_t            pend_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: architectural meaning of the instruction, independent of buffering.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst,
                                   input logic [31:0] res, input logic [31:0] ld);
        exp_t e;
        logic [6:0] op;
        int unsigned off;
        logic [31:0] v;
        op     = inst[6:0];
        off    = int'(res[1:0]);
        e.pc   = pc;
        e.rd   = inst[11:7];
        e.wr   = (op inside {7'h33, 7'h13, 7'h67, 7'h03, 7'h37, 7'h17, 7'h6F}) && inst[11:7] != 0;
        e.data = res;
        if (op == 7'h03) begin
            case (inst[14:12])
                3'b000, 3'b100: begin
                    v = (ld >> (8 * off)) & 32'hFF;
                    e.data = (inst[14:12] == 3'b000 && v >= 128) ? v - 32'd256 : v;
                end
                3'b001, 3'b101: begin
                    v = (ld >> (16 * (off / 2))) & 32'hFFFF;
                    e.data = (inst[14:12] == 3'b001 && v >= 32768) ? v - 32'd65536 : v;
                end
                default: e.data = ld;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk) rst_q <= rst;

    // Monitor: OUT slot must always present the oldest outstanding instruction.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sbq.delete();
            n_ret = 0;
            chk("rst_retire", 64'(retire_o), 64'd0);
            chk("rst_rdvalid", 64'(rdvalid_o), 64'd0);
        end else begin
            bit exp_ret;
            chk("ready", 64'(ready_o), 64'(!rst_q && sbq.size() < 2));
`ifdef WB_INSTRET_EN
            chk("instret", 64'(instret_o), 64'(n_ret));
`endif
            if (sbq.size() > 0) begin
                exp_ret = sbq[0].wr ? rf_ready_i : 1'b1;
                chk("rdvalid", 64'(rdvalid_o), 64'(sbq[0].wr));
                if (sbq[0].wr) begin
                    chk("rdnum", 64'(rdnum_o), 64'(sbq[0].rd));
                    chk("rddata", 64'(rddata_o), 64'(sbq[0].data));
                end
                chk("retire", 64'(retire_o), 64'(exp_ret));
                if (exp_ret) begin
                    chk("retire_pc", 64'(retire_pc_o), 64'(sbq[0].pc));
                    void'(sbq.pop_front());
                    n_ret++;
                end
            end else begin
                chk("idle_rdvalid", 64'(rdvalid_o), 64'd0);
                chk("idle_retire", 64'(retire_o), 64'd0);
            end
        end
    end

    // One cycle of driving, starting just after a rising edge.
    task automatic offer(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] res, input logic [31:0] ld, input bit rfr,
                         output bit acc);
        valid_i    = v;
        pc_i       = pc;
        inst_i     = inst;
        result_i   = res;
        loaddata_i = ld;
        rf_ready_i = rfr;
        acc        = v && ready_o;
        pend       = acc;
        pend_e     = model(pc, inst, res, ld);
        @(posedge clk);
        #1;
        if (pend) sbq.push_back(pend_e);
        pend    = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] res, input logic [31:0] ld, input bit rfr);
        bit acc;
        for (int i = 0; i < 50; i++) begin
            offer(1'b1, pc, inst, res, ld, rfr, acc);
            if (acc) return;
        end
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain(input bit rfr);
        bit acc;
        for (int i = 0; i < 20 && sbq.size() > 0; i++)
            offer(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, rfr, acc);
        chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        pend    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdnum", 64'(rdnum_o), 64'd0);
        chk("post_rst_rddata", 64'(rddata_o), 64'd0);
        chk("post_rst_pc", 64'(retire_pc_o), 64'd0);
        chk("post_rst_ready", 64'(ready_o), 64'd0);
`ifdef WB_INSTRET_EN
        chk("post_rst_instret", 64'(instret_o), 64'd0);
`endif
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(ready_o), 64'd1);
    endtask

    localparam logic [31:0] LD_WORD = 32'h80FF7F01;

    initial begin
        bit acc;
        logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h23, 7'h63, 7'h73};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADDI x5 then LUI x6 back to back
        send(32'h100, {12'h011, 5'd0, 3'b000, 5'd5, 7'h13}, 32'h11, 32'h0, 1'b1);
        send(32'h104, {20'hABCDE, 5'd6, 7'h37}, 32'hABCDE000, 32'h0, 1'b1);
        drain(1'b1);

        // Load extraction: LB, LBU at offset 3; LH, LHU at offset 2; LW and odd funct3
        send(32'h200, {12'h0, 5'd1, 3'b000, 5'd7, 7'h03}, 32'h1003, LD_WORD, 1'b1);
        send(32'h204, {12'h0, 5'd1, 3'b100, 5'd8, 7'h03}, 32'h1003, LD_WORD, 1'b1);
        send(32'h208, {12'h0, 5'd1, 3'b001, 5'd9, 7'h03}, 32'h1002, LD_WORD, 1'b1);
        send(32'h20C, {12'h0, 5'd1, 3'b101, 5'd10, 7'h03}, 32'h1002, LD_WORD, 1'b1);
        send(32'h210, {12'h0, 5'd1, 3'b001, 5'd11, 7'h03}, 32'h1003, LD_WORD, 1'b1);
        send(32'h214, {12'h0, 5'd1, 3'b010, 5'd12, 7'h03}, 32'h1001, LD_WORD, 1'b1);
        send(32'h218, {12'h0, 5'd1, 3'b110, 5'd13, 7'h03}, 32'h1000, LD_WORD, 1'b1);
        drain(1'b1);

        // RF stall: three writers offered while the write port is blocked
        for (int i = 0; i < 3; i++)
            offer(1'b1, 32'h300 + 32'(4 * i), {12'h0, 5'd0, 3'b000, 5'(14 + i), 7'h13},
                  32'h1000 + 32'(i), 32'h0, 1'b0, acc);
        send(32'h308, {12'h0, 5'd0, 3'b000, 5'd16, 7'h13}, 32'h1002, 32'h0, 1'b1);
        drain(1'b1);

        // Non-writers commit regardless of rf_ready
        send(32'h400, {7'h0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33}, 32'h55, 32'h0, 1'b0);
        send(32'h404, {7'h0, 5'd2, 5'd1, 3'b010, 5'd4, 7'h23}, 32'h66, 32'h0, 1'b0);
        send(32'h408, {7'h0, 5'd2, 5'd1, 3'b000, 5'd8, 7'h63}, 32'h77, 32'h0, 1'b0);
        drain(1'b0);

        // Reset with both slots full
        send(32'h500, {12'h0, 5'd0, 3'b000, 5'd20, 7'h13}, 32'hAA, 32'h0, 1'b0);
        send(32'h504, {12'h0, 5'd0, 3'b000, 5'd21, 7'h13}, 32'hBB, 32'h0, 1'b0);
        do_reset();
        drain(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            offer($urandom_range(0, 9) < 7, $urandom, {17'($urandom), 3'($urandom), rd, ops[$urandom_range(0, 9)]},
                  $urandom, $urandom, $urandom_range(0, 9) < 6, acc);
        end
        drain(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_stage_rv.md
Name: wb_stage_rv

Overview:
Registered writeback stage for the RV32 pipeline, the parametrised successor to the combinational writeback. Accepts retiring instructions from the memory stage over a valid/ready handshake and buffers them in a 2-entry skid buffer. Performs load sub-word extraction and sign extension, then drives the register-file write port, which may stall. Emits a retire pulse and, optionally, an instret counter.

Parameters:
XLEN, 32, datapath width; result_i, loaddata_i, rddata_o and pc widths.
CNT_W, 64, instret counter width; used only with WB_INSTRET_EN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
valid_i  in  1  upstream instruction valid
ready_o  out  1  stage can accept; registered
pc_i  in  XLEN  instruction PC
inst_i  in  32  instruction word
result_i  in  XLEN  ALU/branch-link result; byte address for loads
loaddata_i  in  XLEN  aligned memory read word for loads
rf_ready_i  in  1  register-file write port accepts this cycle
rdvalid_o  out  1  register write request
rdnum_o  out  5  destination register
rddata_o  out  XLEN  write data
retire_o  out  1  one-cycle pulse per committed instruction
retire_pc_o  out  XLEN  PC of the committing instruction
instret_o  out  CNT_W  retired-instruction count (WB_INSTRET_EN only)

Behaviour:
- Accept = valid_i & ready_o. ready_o = ~skid_valid, registered.
- Two slots: OUT (drives outputs) and SKID. Accept with OUT empty, or with OUT committing and SKID empty, loads OUT. Accept while OUT is held loads SKID. On OUT commit with SKID full, SKID moves to OUT and SKID clears. Program order is always preserved.
- Latency: with an empty stage, rdvalid_o asserts the cycle after accept.
- writes_rd is true for opcode inst[6:0] in {0110011 OP, 0010011 OP-IMM, 1100111 JALR, 0000011 LOAD, 0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- rdvalid_o = out_valid & writes_rd & (rd != 0). An rd=x0 write is suppressed but the instruction still retires.
- Commit = out_valid & (rf_ready_i | ~rdvalid_o). Non-writing instructions (store, branch, system) commit without waiting on rf_ready_i.
- rdnum_o = inst[11:7]. rddata_o = captured data. Both hold stable while rdvalid_o is high and uncommitted.
- Load extraction happens at capture. Offset = result_i[1:0], funct3 = inst[14:12]:
  - 000 LB: sign-extend byte[offset]
  - 001 LH: sign-extend half[offset[1]]
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - Other funct3 values pass the word through.
  - Misaligned LH ignores offset[0].
- Non-load instructions capture result_i.
- retire_o = commit; retire_pc_o = OUT pc, valid when retire_o is high.
- Reset: all slots invalid; ready_o=0 during reset and 1 the cycle after; rdvalid_o=0, rdnum_o=0, rddata_o=0, retire_o=0, retire_pc_o=0, instret_o=0. Reset mid-operation discards buffered instructions without writing or retiring them.
- Simultaneous accept and commit with SKID empty: OUT is replaced in the same edge, giving a back-to-back throughput of 1 per cycle.

Optional Feature:
WB_INSTRET_EN
- Defined: instret_o exists. It increments by 1 on each commit, wraps modulo 2^CNT_W, and resets to 0.
- Undefined: instret_o port and counter are absent; all other behaviour is identical.

Test Plan:
- Back-to-back ADDI x5 (result 0x11), LUI x6 (result 0xABCDE000), rf_ready_i=1 -> rdvalid_o high for two consecutive cycles with rd 5/6 and the matching data. retire_o pulses twice; instret_o=2.
- LB with result_i=0x1003, loaddata_i=0x80FF7F01 -> rddata_o=0xFFFFFF80. The same load as LBU gives 0x00000080; LH at offset 2 gives 0xFFFF80FF; LHU at offset 2 gives 0x000080FF.
- rf_ready_i held low for 3 cycles with 3 writing instructions offered -> OUT and SKID fill and ready_o drops. On release, three writes occur in order with no loss or duplication.
- ADD rd=x0, then SW, then BEQ, with rf_ready_i=0 -> rdvalid_o never asserts, all three retire on consecutive cycles, and instret_o=3.
- Assert rst while both slots are full -> no write or retire follows. All outputs are 0 and instret_o=0 on the cycle after reset; ready_o=1 one cycle after reset deasserts.
